// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration sequencer.
package lut_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int WORDS_PER_LUT(input int mem_size, input int word_width);
        return mem_size / word_width;
    endfunction

    // Counter width that stays legal (>=1 bit) even for a single-entry range.
    function automatic int CNT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_cfg_assembler.sv
// Packs bitstream words LSB-first into one truth table; 0-cycle flag latency, accepts whenever accept is high.
module lut_cfg_assembler
    import lut_cfg_pkg::*;
#(
    parameter int MEM_SIZE   = 16,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  restart,
    input  logic                  accept,
    input  logic [WORD_WIDTH-1:0] word,
    output logic [MEM_SIZE-1:0]   tbl,
    output logic                  last
);

    localparam int WPL = WORDS_PER_LUT(MEM_SIZE, WORD_WIDTH);
    localparam int CW  = CNT_W(WPL);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(WPL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tbl <= '0;
        end else if (clear) begin
            cnt <= '0;
            tbl <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (accept) begin
            tbl[cnt*WORD_WIDTH +: WORD_WIDTH] <= word;
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lut_config_ctrl.sv
// Sequences a word-serial bitstream into one-hot LUT writes; WPL+1 cycles per LUT, stalls on in_valid low.
// LUT_CFG_CHECKSUM_EN adds a trailing XOR checksum word and the err flag.
module lut_config_ctrl
    import lut_cfg_pkg::*;
#(
    parameter int NUM_LUTS   = 8,
    parameter int INPUTS     = 4,
    parameter int MEM_SIZE   = 2**INPUTS,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  config_clk,
    input  logic                  config_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic [NUM_LUTS-1:0]   lut_config_en,
    output logic [MEM_SIZE-1:0]   lut_config_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IW = CNT_W(NUM_LUTS);

    state_t              state, state_nxt;
    logic [IW-1:0]       idx;
    logic [MEM_SIZE-1:0] tbl;
    logic [MEM_SIZE-1:0] data_hold;
    logic                last;
    logic                accept;
    logic                begin_load;
    logic                idx_last;

    assign in_ready   = (state == ST_LOAD) || (state == ST_CHECK);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE) && !abort;
    assign accept     = (state == ST_LOAD) && in_valid && !abort;
    assign begin_load = (state == ST_IDLE) && start && !abort;
    assign idx_last   = (idx == IW'(NUM_LUTS - 1));

    // The live table is shown during WRITE; afterwards the bus keeps the last table.
    assign lut_config_data = (state == ST_WRITE) ? tbl : data_hold;

    lut_cfg_assembler #(
        .MEM_SIZE   (MEM_SIZE),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_asm (
        .clk     (config_clk),
        .rst     (config_rst),
        .clear   (begin_load),
        .restart (state == ST_WRITE),
        .accept  (accept),
        .word    (in_data),
        .tbl     (tbl),
        .last    (last)
    );

    always_comb begin
        lut_config_en = '0;
        if (state == ST_WRITE && !abort) begin
            for (int i = 0; i < NUM_LUTS; i++) begin
                lut_config_en[i] = (idx == IW'(i));
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  if (accept && last) state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (!idx_last) begin
                    state_nxt = ST_LOAD;
                end else begin
`ifdef LUT_CFG_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef LUT_CFG_CHECKSUM_EN
            ST_CHECK: if (in_valid) state_nxt = ST_DONE;
`endif
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            data_hold <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_WRITE) data_hold <= tbl;
            if (begin_load) begin
                idx <= '0;
            end else if (state == ST_WRITE && !abort && !idx_last) begin
                idx <= idx + IW'(1);
            end
        end
    end

`ifdef LUT_CFG_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum;
    logic                  err_q;

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (begin_load) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) csum <= csum ^ in_data;
            if (state == ST_CHECK && in_valid && !abort) err_q <= (in_data != csum);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_config_ctrl.sv
// Directed and randomized bench for lut_config_ctrl against a table/timing reference model.
module tb_lut_config_ctrl;

    localparam int N   = 2;
    localparam int W   = 8;
    localparam int WPL = 2;
`ifdef LUT_CFG_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start1 = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, busy, done, err;
    logic [1:0]  en;
    logic [15:0] data;
    logic        in_ready1, busy1, done1, err1;
    logic [0:0]  en1;
    logic [15:0] data1;

    lut_config_ctrl #(.NUM_LUTS(N), .INPUTS(4), .WORD_WIDTH(W)) u_dut (
        .config_clk(clk), .config_rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lut_config_en(en), .lut_config_data(data),
        .busy(busy), .done(done), .err(err)
    );

    lut_config_ctrl #(.NUM_LUTS(1), .INPUTS(4), .WORD_WIDTH(W)) u_dut1 (
        .config_clk(clk), .config_rst(rst), .start(start1), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .lut_config_en(en1), .lut_config_data(data1),
        .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [1:0]  e;
        logic [15:0] d;
    } wr_t;

    wr_t  wq[$];
    int   dq[$];
    int   onehot_bad = 0, consec_bad = 0;
    logic prev_en = 1'b0;
    int   b_wr = 0, b_done = -1;
    logic [15:0] b_dat = '0;

    always @(negedge clk) begin
        if (en != 2'b00) begin
            wq.push_back('{cyc, en, data});
            if ($countones(en) != 1) onehot_bad <= onehot_bad + 1;
            if (prev_en) consec_bad <= consec_bad + 1;
        end
        prev_en <= (en != 2'b00);
        if (done) dq.push_back(cyc);
        if (en1[0]) begin
            b_wr  <= b_wr + 1;
            b_dat <= data1;
        end
        if (done1) b_done <= cyc;
    end

    int vectors = 0, fails = 0, busy_low = 0;
    bit hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sel);
        bit acc;
        int g;
        in_valid = 1'b1;
        in_data  = d;
        g = 0;
        do begin
            @(negedge clk);
            acc = sel ? in_ready1 : in_ready;
            @(posedge clk);
            #1;
            if (!hold) begin
                start  = 1'b0;
                start1 = 1'b0;
            end
            g++;
        end while (!acc && g < 40);
        chk("handshake", acc, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (!busy) busy_low++;
        end
    endtask

    // Model: LUT l strobes after its WPL words plus earlier write cycles and inserted bubbles.
    task automatic run_load(input logic [7:0] w[4], input int bub[4], input logic [7:0] ck);
        int t0, bsum, ed;
        int ec[N];
        logic [15:0] et[N];
        logic [7:0] x;
        logic exp_err;
        x = '0;
        bsum = 0;
        for (int l = 0; l < N; l++) begin
            et[l] = '0;
            for (int k = 0; k < WPL; k++) begin
                et[l] = et[l] | (16'(w[l*WPL+k]) << (k*W));
                x = x ^ w[l*WPL+k];
                if (k != 0) bsum += bub[l*WPL+k];
            end
            ec[l] = 1 + (l+1)*WPL + l + bsum;
        end
        exp_err = (CK != 0) && (ck != x);
        ed = ec[N-1] + 1 + CK;
        wq.delete();
        dq.delete();
        busy_low = 0;
        t0 = cyc;
        start = 1'b1;
        for (int j = 0; j < N*WPL; j++) begin
            if (j % WPL != 0) idle(bub[j]);
            send(w[j], 1'b0);
        end
`ifdef LUT_CFG_CHECKSUM_EN
        send(ck, 1'b0);
`endif
        in_valid = 1'b0;
        start = 1'b0;
        while (cyc < t0 + ed + 2) @(posedge clk);
        #1;
        chk("write_count", wq.size(), N);
        for (int l = 0; l < N && l < wq.size(); l++) begin
            chk("write_en", wq[l].e, 2'b01 << l);
            chk("write_data", wq[l].d, et[l]);
            chk("write_cycle", wq[l].c - t0, ec[l]);
        end
        chk("done_count", dq.size(), 1);
        if (dq.size() > 0) chk("done_cycle", dq[0] - t0, ed);
        chk("err", err, exp_err);
        chk("busy_in_bubbles", busy_low, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        logic [7:0] rw[4];
        int rb[4];
        logic [7:0] rx, rck;
        int t0, b0;

        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_en", en, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_load('{8'h34, 8'h12, 8'hCD, 8'hAB}, '{0, 0, 0, 0}, 8'h40);
        run_load('{8'h34, 8'h12, 8'hCD, 8'hAB}, '{0, 2, 0, 2}, 8'h41);
        hold = 1'b1;
        run_load('{8'h5A, 8'hA5, 8'h0F, 8'hF0}, '{0, 1, 0, 0}, 8'h00);
        hold = 1'b0;

        repeat (5) begin
            rx = '0;
            for (int i = 0; i < 4; i++) begin
                rw[i] = 8'($urandom);
                rb[i] = $urandom_range(0, 2);
                rx = rx ^ rw[i];
            end
            rck = ($urandom_range(0, 1) != 0) ? rx : rx ^ 8'($urandom_range(1, 255));
            run_load(rw, rb, rck);
        end

        // Abort during the final write cycle.
        wq.delete();
        dq.delete();
        start = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        abort = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_en", en, 0);
        chk("abort_done", done, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", wq.size(), 1);
        if (wq.size() > 0) chk("abort_first_en", wq[0].e, 2'b01);
        chk("abort_no_done", dq.size(), 0);
        run_load('{8'h01, 8'h02, 8'h03, 8'h04}, '{0, 0, 0, 0}, 8'h04);

        // Reset after the first word of a load.
        start = 1'b1;
        send(8'h77, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_en", en, 0);
        chk("midrst_data", data, 0);
        chk("midrst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_load('{8'hDE, 8'hAD, 8'hBE, 8'hEF}, '{0, 0, 0, 1}, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);

        // Single-LUT bank.
        b0 = b_wr;
        t0 = cyc;
        start1 = 1'b1;
        send(8'hC3, 1'b1);
        send(8'h3C, 1'b1);
`ifdef LUT_CFG_CHECKSUM_EN
        send(8'hFF, 1'b1);
`endif
        in_valid = 1'b0;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("one_lut_strobes", b_wr - b0, 1);
        chk("one_lut_data", b_dat, 16'h3CC3);
        chk("one_lut_done_cycle", b_done - t0, 4 + CK);
        chk("one_lut_err", err1, 0);

        chk("onehot", onehot_bad, 0);
        chk("no_back_to_back", consec_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/lut_config_ctrl.md
# lut_config_ctrl

Configuration sequencer for a bank of LUTs sharing one configuration bus. It accepts a word-serial bitstream through a valid/ready handshake and assembles each LUT's full truth table from consecutive words. It then writes the table into exactly one LUT by pulsing that LUT's config enable for one cycle, and repeats until every LUT in the bank is programmed. It sits between the bitstream source (fabric configuration port or test loader) and the `config_en` / `config_in` inputs of the LUT instances.

## Interface
- `NUM_LUTS`, default 8: number of LUTs in the bank (≥1).
- `INPUTS`, default 4: LUT address width.
- `MEM_SIZE`, default 2**INPUTS: bits per LUT truth table.
- `WORD_WIDTH`, default 8: bitstream word width. `MEM_SIZE` must be a multiple of `WORD_WIDTH`. WPL = `MEM_SIZE`/`WORD_WIDTH`.
- `config_clk`, input, 1: sole clock; all state updates on the rising edge.
- `config_rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a bank load; sampled only in IDLE.
- `abort`, input, 1: synchronous cancel; return to IDLE from any state.
- `in_valid`, input, 1: bitstream word valid.
- `in_ready`, output, 1: controller accepts a word this cycle.
- `in_data`, input, `WORD_WIDTH`: bitstream word.
- `lut_config_en`, output, `NUM_LUTS`: one-hot write strobe, one bit per LUT.
- `lut_config_data`, output, `MEM_SIZE`: shared truth-table bus to all LUTs.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when the bank load completes.
- `err`, output, 1: checksum mismatch flag (see Configuration).

## Operation
- **States:** IDLE, LOAD, WRITE, CHECK (macro only), DONE.
- **IDLE:**
  - `in_ready`=0.
  - `start`=1 → LOAD. This clears the word counter, the LUT index, the assembly register and `err`.
- **LOAD:**
  - `in_ready`=1.
  - Each cycle with `in_valid`&&`in_ready`, the word is stored at bits [k·W +: W], where k is the word counter (0..WPL-1). The first word lands in the LSBs.
  - Acceptance of word WPL-1 → WRITE.
- **WRITE:**
  - `in_ready`=0.
  - `lut_config_en[idx]`=1 for exactly one cycle, with `lut_config_data` equal to the assembled table.
  - If idx < `NUM_LUTS`-1: increment idx, clear the word counter, → LOAD.
  - Otherwise → CHECK when the macro is defined, else → DONE.
- **CHECK:**
  - `in_ready`=1.
  - Accept one word, compare it with the running checksum, set `err` on mismatch, → DONE.
- **DONE:**
  - `done`=1 for one cycle, → IDLE.
- **Idle `in_valid`:** while `in_valid`=0 in LOAD or CHECK, the controller holds state and contents indefinitely.
- **`start` outside IDLE:** ignored.
- **`abort`:**
  - Has priority over every other transition. The next state is IDLE.
  - Suppresses any `lut_config_en` pulse in the cycle it is asserted. A WRITE cycle with `abort`=1 writes nothing.
  - LUTs already written keep their contents. `done` does not pulse.
- **`lut_config_data`:** holds its last value outside WRITE. Only `lut_config_en` qualifies it.

## Timing
- **Reset values:** state=IDLE. `in_ready`=0, `lut_config_en`=0, `lut_config_data`=0, `busy`=0, `done`=0, `err`=0.
- Reset asserted mid-load returns to IDLE asynchronously with no further strobes.
- All outputs are derived from registered state. There is no combinational path from `in_valid` to `in_ready`.
- **Latency with `in_valid` held at 1:** `start` sampled at cycle 0; LOAD begins at cycle 1.
  - Each LUT takes WPL+1 cycles (WPL word cycles plus 1 write cycle).
  - `done` is high in cycle 1+NUM_LUTS·(WPL+1). Add 1 cycle when the macro is defined.
- `lut_config_en` is never more than one bit high, and never high in two consecutive cycles.

## Configuration
- **`LUT_CFG_CHECKSUM_EN` defined:**
  - A running XOR of every accepted table word is kept and cleared on `start`.
  - After the last WRITE, CHECK consumes one extra word. `err`=1 if that word differs from the XOR.
  - `err` holds until the next `start` or reset.
- **Not defined:** the CHECK state and XOR register are absent, `err` is tied to 0, and the stream is exactly NUM_LUTS·WPL words.

## Structure
- **Package `lut_cfg_pkg`:** the state enum type, and a `WORDS_PER_LUT` function of (`MEM_SIZE`, `WORD_WIDTH`) used for counter widths.
- **Sub-module `lut_cfg_assembler`:** word-to-table assembly register, word counter and last-word flag. The controller FSM, LUT index, one-hot decode and checksum stay in `lut_config_ctrl`.

## Test plan
All scenarios use `NUM_LUTS`=2, `INPUTS`=4, `WORD_WIDTH`=8 unless stated.
- **Basic load:** `start`, then words 0x34, 0x12, 0xCD, 0xAB with `in_valid` constant → `lut_config_en`=01 with data 0x1234 at cycle 3, `lut_config_en`=10 with data 0xABCD at cycle 6, `done` at cycle 7.
- **Bubbles:** `in_valid` toggling 1,0,0,1 between words → same two writes and data, delayed by exactly the number of idle cycles. `busy` stays 1 throughout.
- **Abort:** `abort` asserted in the WRITE cycle of LUT1 → no strobe on bit 1, no `done`, IDLE next cycle. A following `start` reloads from LUT0.
- **Reset mid-LOAD:** `config_rst` pulsed after the first word → all outputs return to reset values immediately. `start` plus 4 fresh words then programs normally.
- **Checksum (macro on):** words 0x34, 0x12, 0xCD, 0xAB, then 0x40 → `err`=0. Trailing word 0x41 → `err`=1. `done` pulses in both cases.
- **Ignored start:** `start` held at 1 during LOAD → no restart and the word counter is unaffected. `NUM_LUTS`=1 → exactly one strobe, then `done`.
